// File: rtl/bpu_upd_pkg.sv
// Shared types for the branch-predictor update scheduler: queued update entry and FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// BHT index width comes from `BHTBTB_INDEX_WIDTH (defaults to 8 when not supplied by the build).
`ifndef BHTBTB_INDEX_WIDTH
`define BHTBTB_INDEX_WIDTH 8
`endif

package bpu_upd_pkg;

  localparam int BHT_IDX_W = `BHTBTB_INDEX_WIDTH;
  localparam int BTB_IDX_W = 9;
  localparam int BTB_DAT_W = 129;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } bpu_upd_state_t;

  typedef struct packed {
    logic                 bht_we;
    logic                 bht_inc;
    logic                 bht_dec;
    logic [BHT_IDX_W-1:0] bht_index;
    logic [1:0]           bht_sel;
    logic                 bht_valid;
    logic                 btb_we;
    logic [BTB_IDX_W-1:0] btb_index;
    logic [BTB_DAT_W-1:0] btb_wmask;
    logic [BTB_DAT_W-1:0] btb_din;
  } bpu_upd_entry_t;

  // An entry may write this cycle unless it needs the BTB SRAM while the
  // frontend is reading it; a forced write overrides the frontend.
  function automatic logic entry_drainable(input bpu_upd_entry_t e,
                                           input logic fe_rd,
                                           input logic forced);
    return !e.btb_we || !fe_rd || forced;
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// In-order storage for pending BPU updates (DEPTH x bpu_upd_entry_t, DEPTH power of two >= 2).
// Latency: pushed entry is visible at head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/count exported.
// Ports: clock, reset_n, push/push_dat, pop, head, full, empty, count.
module bpu_upd_fifo
  import bpu_upd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  bpu_upd_entry_t         push_dat,
  input  logic                   pop,
  output bpu_upd_entry_t         head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bpu_upd_entry_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed through a valid head.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/bpu_update_sched.sv
// Queues writeback-stage BHT/BTB updates and schedules them onto the BHT port and the
// single-port BTB SRAM, yielding to frontend BTB reads until a starvation limit forces a write.
// Latency: >=1 cycle accept-to-write (0 cycles with BPU_UPD_BYPASS_EN when queue empty and drainable).
// Backpressure: upd_ready = !full (not drain-aware); fe_stall asserted only during a forced write.
// Ports: clock/reset_n; upd_* request in; fe_btb_rd in, fe_stall out; bht_* and btb_* write ports; q_count.
// Optional macro: BPU_UPD_BYPASS_EN enables the empty-queue same-cycle bypass.
module bpu_update_sched
  import bpu_upd_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic                   upd_bht_we,
  input  logic                   upd_bht_inc,
  input  logic                   upd_bht_dec,
  input  logic [BHT_IDX_W-1:0]   upd_bht_index,
  input  logic [1:0]             upd_bht_sel,
  input  logic                   upd_bht_valid,
  input  logic                   upd_btb_we,
  input  logic [BTB_IDX_W-1:0]   upd_btb_index,
  input  logic [BTB_DAT_W-1:0]   upd_btb_wmask,
  input  logic [BTB_DAT_W-1:0]   upd_btb_din,
  input  logic                   fe_btb_rd,
  output logic                   fe_stall,
  output logic                   bht_we,
  output logic                   bht_inc,
  output logic                   bht_dec,
  output logic                   bht_valid,
  output logic [BHT_IDX_W-1:0]   bht_index,
  output logic [1:0]             bht_sel,
  output logic                   btb_ce,
  output logic                   btb_we,
  output logic [BTB_IDX_W-1:0]   btb_index,
  output logic [BTB_DAT_W-1:0]   btb_wmask,
  output logic [BTB_DAT_W-1:0]   btb_din,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int              SW         = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT - 1);

  bpu_upd_entry_t in_ent;
  bpu_upd_entry_t head;
  bpu_upd_entry_t wr_ent;
  bpu_upd_state_t state;
  logic [SW-1:0]  starve_cnt;
  logic [SW-1:0]  starve_inc;
  logic           full;
  logic           empty;
  logic           accept;
  logic           bypass;
  logic           push;
  logic           head_drain;
  logic           blocked;
  logic           wr_vld;

  always_comb begin
    in_ent           = '0;
    in_ent.bht_we    = upd_bht_we;
    in_ent.bht_inc   = upd_bht_inc;
    in_ent.bht_dec   = upd_bht_dec;
    in_ent.bht_index = upd_bht_index;
    in_ent.bht_sel   = upd_bht_sel;
    in_ent.bht_valid = upd_bht_valid;
    in_ent.btb_we    = upd_btb_we;
    in_ent.btb_index = upd_btb_index;
    in_ent.btb_wmask = upd_btb_wmask;
    in_ent.btb_din   = upd_btb_din;
  end

  // Requests carrying no write enable are dropped rather than occupying a slot.
  assign upd_ready  = !full;
  assign accept     = upd_valid && !full && (upd_bht_we || upd_btb_we);
  assign head_drain = !empty && entry_drainable(head, fe_btb_rd, state == FORCE);
  assign blocked    = !empty && !head_drain;

`ifdef BPU_UPD_BYPASS_EN
  // Only an empty queue may be bypassed, otherwise ordering would break.
  assign bypass = accept && empty && entry_drainable(in_ent, fe_btb_rd, 1'b0);
`else
  assign bypass = 1'b0;
`endif

  assign push   = accept && !bypass;
  assign wr_vld = head_drain || bypass;
  assign wr_ent = head_drain ? head : in_ent;

  bpu_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (in_ent),
    .pop      (head_drain),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (q_count)
  );

  // Write ports are zero unless the corresponding enable fires, so idle
  // cycles never present stale index/data to the arrays.
  assign bht_we    = wr_vld && wr_ent.bht_we;
  assign bht_inc   = bht_we && wr_ent.bht_inc;
  assign bht_dec   = bht_we && wr_ent.bht_dec;
  assign bht_valid = bht_we && wr_ent.bht_valid;
  assign bht_index = bht_we ? wr_ent.bht_index : '0;
  assign bht_sel   = bht_we ? wr_ent.bht_sel   : '0;

  assign btb_we    = wr_vld && wr_ent.btb_we;
  assign btb_ce    = btb_we;
  assign btb_index = btb_we ? wr_ent.btb_index : '0;
  assign btb_wmask = btb_we ? wr_ent.btb_wmask : '0;
  assign btb_din   = btb_we ? wr_ent.btb_din   : '0;

  // Frontend reads win except in the one cycle a starved write is forced.
  assign fe_stall  = (state == FORCE) && fe_btb_rd;

  assign starve_inc = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;

  // FORCE is entered on the edge where the counter reaches STARVE_LIMIT-1, so the
  // forced write lands after STARVE_LIMIT-1 blocked cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      if (btb_we)       starve_cnt <= '0;
      else if (blocked) starve_cnt <= starve_inc;

      case (state)
        IDLE, WAIT: begin
          if (blocked) state <= (starve_inc == STARVE_MAX) ? FORCE : WAIT;
          else         state <= IDLE;
        end
        FORCE:   state <= IDLE;   // head always drains while forced
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed bench for bpu_update_sched with an in-order write scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_bpu_update_sched;
  import bpu_upd_pkg::*;

  typedef struct packed {
    logic                 bht_we;
    logic                 bht_inc;
    logic                 bht_dec;
    logic                 bht_valid;
    logic [BHT_IDX_W-1:0] bht_index;
    logic [1:0]           bht_sel;
    logic                 btb_we;
    logic [BTB_IDX_W-1:0] btb_index;
    logic [BTB_DAT_W-1:0] btb_wmask;
    logic [BTB_DAT_W-1:0] btb_din;
  } wr_rec_t;

  logic                 clock;
  logic                 reset_n;
  logic                 upd_valid;
  logic                 upd_ready;
  logic                 upd_bht_we, upd_bht_inc, upd_bht_dec;
  logic [BHT_IDX_W-1:0] upd_bht_index;
  logic [1:0]           upd_bht_sel;
  logic                 upd_bht_valid;
  logic                 upd_btb_we;
  logic [BTB_IDX_W-1:0] upd_btb_index;
  logic [BTB_DAT_W-1:0] upd_btb_wmask, upd_btb_din;
  logic                 fe_btb_rd;
  logic                 fe_stall;
  logic                 bht_we, bht_inc, bht_dec, bht_valid;
  logic [BHT_IDX_W-1:0] bht_index;
  logic [1:0]           bht_sel;
  logic                 btb_ce, btb_we;
  logic [BTB_IDX_W-1:0] btb_index;
  logic [BTB_DAT_W-1:0] btb_wmask, btb_din;
  logic [2:0]           q_count;

  int      vectors     = 0;
  int      miscompares = 0;
  wr_rec_t exp_q[$];
  wr_rec_t mon_obs;
  wr_rec_t mon_exp;

  bpu_update_sched #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_bht_we    (upd_bht_we),
    .upd_bht_inc   (upd_bht_inc),
    .upd_bht_dec   (upd_bht_dec),
    .upd_bht_index (upd_bht_index),
    .upd_bht_sel   (upd_bht_sel),
    .upd_bht_valid (upd_bht_valid),
    .upd_btb_we    (upd_btb_we),
    .upd_btb_index (upd_btb_index),
    .upd_btb_wmask (upd_btb_wmask),
    .upd_btb_din   (upd_btb_din),
    .fe_btb_rd     (fe_btb_rd),
    .fe_stall      (fe_stall),
    .bht_we        (bht_we),
    .bht_inc       (bht_inc),
    .bht_dec       (bht_dec),
    .bht_valid     (bht_valid),
    .bht_index     (bht_index),
    .bht_sel       (bht_sel),
    .btb_ce        (btb_ce),
    .btb_we        (btb_we),
    .btb_index     (btb_index),
    .btb_wmask     (btb_wmask),
    .btb_din       (btb_din),
    .q_count       (q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_upd();
    upd_valid     = 1'b0;
    upd_bht_we    = 1'b0;
    upd_bht_inc   = 1'b0;
    upd_bht_dec   = 1'b0;
    upd_bht_index = '0;
    upd_bht_sel   = '0;
    upd_bht_valid = 1'b0;
    upd_btb_we    = 1'b0;
    upd_btb_index = '0;
    upd_btb_wmask = '0;
    upd_btb_din   = '0;
  endtask

  // Drives one request for the current cycle and records the write it must produce.
  task automatic drive_upd(input logic bwe, input logic inc, input logic dec, input logic bval,
                           input logic [BHT_IDX_W-1:0] bidx, input logic [1:0] sel,
                           input logic twe, input logic [BTB_IDX_W-1:0] tidx);
    wr_rec_t r;
    logic [BTB_DAT_W-1:0] m, d;
    m = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
    d = {$urandom, $urandom, $urandom, $urandom, 1'($urandom)};
    upd_valid     = 1'b1;
    upd_bht_we    = bwe;
    upd_bht_inc   = inc;
    upd_bht_dec   = dec;
    upd_bht_valid = bval;
    upd_bht_index = bidx;
    upd_bht_sel   = sel;
    upd_btb_we    = twe;
    upd_btb_index = tidx;
    upd_btb_wmask = m;
    upd_btb_din   = d;
    r = '0;
    if (bwe) begin
      r.bht_we    = 1'b1;
      r.bht_inc   = inc;
      r.bht_dec   = dec;
      r.bht_valid = bval;
      r.bht_index = bidx;
      r.bht_sel   = sel;
    end
    if (twe) begin
      r.btb_we    = 1'b1;
      r.btb_index = tidx;
      r.btb_wmask = m;
      r.btb_din   = d;
    end
    if (bwe || twe) exp_q.push_back(r);
  endtask

  // Scoreboard: every write cycle must match the oldest outstanding request.
  always @(negedge clock) begin
    if (reset_n && (bht_we || btb_we)) begin
      mon_obs = '{bht_we, bht_inc, bht_dec, bht_valid, bht_index, bht_sel,
                  btb_we, btb_index, btb_wmask, btb_din};
      chk("btb_ce_eq_we", 32'(btb_ce), 32'(btb_we));
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed %h expected none", mon_obs);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        vectors++;
        assert (mon_obs === mon_exp) else begin
          miscompares++;
          $error("FAIL write_record: observed %h expected %h", mon_obs, mon_exp);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    fe_btb_rd = 1'b0;
    clear_upd();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_upd_ready", 32'(upd_ready), 1);
    chk("rst_bht_we", 32'(bht_we), 0);
    chk("rst_btb_we", 32'(btb_we), 0);
    chk("rst_btb_ce", 32'(btb_ce), 0);
    chk("rst_fe_stall", 32'(fe_stall), 0);
    step();

    // BHT-only update while the frontend reads the BTB
    fe_btb_rd = 1'b1;
    drive_upd(1'b1, 1'b1, 1'b0, 1'b1, BHT_IDX_W'(5), 2'd1, 1'b0, 9'h000);
    @(negedge clock);
`ifdef BPU_UPD_BYPASS_EN
    chk("bht_bypass_we", 32'(bht_we), 1);
    chk("bht_bypass_index", 32'(bht_index), 5);
`else
    chk("bht_same_cycle_we", 32'(bht_we), 0);
`endif
    step();
    clear_upd();
    @(negedge clock);
`ifdef BPU_UPD_BYPASS_EN
    chk("bht_next_cycle_we", 32'(bht_we), 0);
`else
    chk("bht_next_cycle_we", 32'(bht_we), 1);
    chk("bht_next_cycle_index", 32'(bht_index), 5);
`endif
    chk("bht_fe_stall", 32'(fe_stall), 0);
    step();

    // Starved BTB write gets forced after STARVE_LIMIT-1 blocked cycles
    drive_upd(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b1, 9'h01A);
    step();
    clear_upd();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk($sformatf("starve_btb_we_c%0d", k), 32'(btb_we), 32'(k == 8));
      chk($sformatf("starve_fe_stall_c%0d", k), 32'(fe_stall), 32'(k == 8));
      if (k == 8) chk("starve_btb_index", 32'(btb_index), 32'h1A);
      step();
    end
    fe_btb_rd = 1'b0;
    @(negedge clock);
    chk("post_force_fe_stall", 32'(fe_stall), 0);
    step();

    // Fill the queue behind a busy frontend, then drain in order
    fe_btb_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_upd(i == 1, 1'b0, 1'b1, 1'b1, BHT_IDX_W'(i + 3), 2'(i), 1'b1, 9'(9'h010 + i));
      step();
    end
    clear_upd();
    @(negedge clock);
    chk("full_upd_ready", 32'(upd_ready), 0);
    chk("full_q_count", 32'(q_count), 4);
    step();
    fe_btb_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("drain_btb_we_%0d", i), 32'(btb_we), 1);
      chk($sformatf("drain_btb_index_%0d", i), 32'(btb_index), 32'(9'h010 + i));
      chk($sformatf("drain_q_count_%0d", i), 32'(q_count), 32'(4 - i));
      step();
    end
    @(negedge clock);
    chk("drained_q_count", 32'(q_count), 0);
    chk("drained_btb_we", 32'(btb_we), 0);
    step();

    // BHT-only entry waits behind a blocked BTB entry
    fe_btb_rd = 1'b1;
    drive_upd(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b1, 9'h033);
    step();
    drive_upd(1'b1, 1'b1, 1'b0, 1'b1, BHT_IDX_W'(9), 2'd3, 1'b0, 9'h000);
    step();
    clear_upd();
    @(negedge clock);
    chk("order_bht_held", 32'(bht_we), 0);
    chk("order_q_count", 32'(q_count), 2);
    step();
    fe_btb_rd = 1'b0;
    @(negedge clock);
    chk("order_first_btb", 32'(btb_we), 1);
    chk("order_first_no_bht", 32'(bht_we), 0);
    step();
    @(negedge clock);
    chk("order_second_bht", 32'(bht_we), 1);
    chk("order_second_no_btb", 32'(btb_we), 0);
    step();

    // Request with no write enable is discarded
    drive_upd(1'b0, 1'b1, 1'b1, 1'b1, BHT_IDX_W'(7), 2'd1, 1'b0, 9'h1FF);
    @(negedge clock);
    chk("noop_upd_ready", 32'(upd_ready), 1);
    step();
    clear_upd();
    @(negedge clock);
    chk("noop_q_count", 32'(q_count), 0);
    chk("noop_bht_we", 32'(bht_we), 0);
    step();

    // Reset with entries queued discards them
    fe_btb_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_upd(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b1, 9'(9'h040 + i));
      step();
    end
    clear_upd();
    @(negedge clock);
    chk("prerst_q_count", 32'(q_count), 3);
    step();
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("midrst_q_count", 32'(q_count), 0);
    chk("midrst_btb_we", 32'(btb_we), 0);
    chk("midrst_fe_stall", 32'(fe_stall), 0);
    step();
    reset_n   = 1'b1;
    fe_btb_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("postrst_btb_we_%0d", i), 32'(btb_we), 0);
      step();
    end
    @(negedge clock);
    chk("postrst_upd_ready", 32'(upd_ready), 1);
    chk("postrst_q_count", 32'(q_count), 0);
    step();

    // BTB update into an empty queue with the SRAM free
    drive_upd(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b1, 9'h055);
    @(negedge clock);
`ifdef BPU_UPD_BYPASS_EN
    chk("empty_btb_same_we", 32'(btb_we), 1);
    chk("empty_btb_same_index", 32'(btb_index), 32'h55);
`else
    chk("empty_btb_same_we", 32'(btb_we), 0);
`endif
    step();
    clear_upd();
    @(negedge clock);
`ifdef BPU_UPD_BYPASS_EN
    chk("empty_btb_next_we", 32'(btb_we), 0);
`else
    chk("empty_btb_next_we", 32'(btb_we), 1);
    chk("empty_btb_next_index", 32'(btb_index), 32'h55);
`endif
    step();

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bpu_update_sched.md
BPU_UPDATE_SCHED -- requirements
Module: bpu_update_sched

Interface
REQ-001 Parameter DEPTH, default 4: update queue entries; power of two, minimum 2.
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive blocked cycles before a BTB write is forced.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 upd_valid  in  1  intwb-stage update request present.
REQ-006 upd_ready  out  1  queue can accept this cycle (not full).
REQ-007 upd_bht_we, upd_bht_inc, upd_bht_dec  in  1 each  BHT write enable and direction.
REQ-008 upd_bht_index  in  `BHTBTB_INDEX_WIDTH  BHT set index.
REQ-009 upd_bht_sel  in  2  BHT counter select.
REQ-010 upd_bht_valid  in  1  BHT valid-bit write value.
REQ-011 upd_btb_we  in  1  BTB write requested.
REQ-012 upd_btb_index  in  9  BTB SRAM index.
REQ-013 upd_btb_wmask, upd_btb_din  in  129 each  BTB bit mask and data.
REQ-014 fe_btb_rd  in  1  frontend wants the single-port BTB SRAM this cycle.
REQ-015 fe_stall  out  1  frontend BTB read denied this cycle.
REQ-016 bht_we, bht_inc, bht_dec, bht_valid  out  1 each; bht_index  out  `BHTBTB_INDEX_WIDTH; bht_sel  out  2: BHT write port.
REQ-017 btb_ce, btb_we  out  1 each; btb_index  out  9; btb_wmask, btb_din  out  129 each: BTB SRAM write port.
REQ-018 q_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Entry accepted when upd_valid && upd_ready && (upd_bht_we || upd_btb_we); a request with neither enable is discarded.
REQ-020 Queue is in-order FIFO; head drains at most one entry per cycle; read/write pointers wrap modulo DEPTH.
REQ-021 Head with upd_btb_we=0: drains every cycle it is valid, driving bht_* only; btb_ce=btb_we=0.
REQ-022 Head with upd_btb_we=1: drains when fe_btb_rd=0 or state FORCE; drives bht_* (if bht_we) and btb_ce=btb_we=1 with stored index/mask/data the same cycle.
REQ-023 FSM states IDLE (queue empty), WAIT (head BTB write blocked by fe_btb_rd), FORCE (forced write).
REQ-024 IDLE->WAIT: head is a BTB write and fe_btb_rd=1; WAIT->FORCE: starve counter reaches STARVE_LIMIT-1 while still blocked; FORCE->IDLE/WAIT after the forced entry drains, per the next head.
REQ-025 Starve counter increments each blocked cycle, clears on any BTB drain, saturates at STARVE_LIMIT-1.
REQ-026 fe_stall=1 only in FORCE while fe_btb_rd=1; otherwise 0 (frontend reads win).
REQ-027 Outputs are combinational from head entry and state; latency from accept to write is >=1 cycle (registered).
REQ-028 Full queue: upd_ready=0; simultaneous drain and accept when full is not permitted (ready is not drain-aware).
REQ-029 Empty queue with accept: q_count 0->1 next cycle; simultaneous accept and drain leaves q_count unchanged.
REQ-030 BHT-only entry behind a blocked BTB entry waits (strict order).

Reset
REQ-031 On reset_n low: pointers, q_count, starve counter cleared; state IDLE; all write-port outputs and fe_stall 0; upd_ready 1 after release.
REQ-032 Reset mid-operation discards all queued updates; no partial SRAM write is issued.

Configuration
REQ-033 BPU_UPD_BYPASS_EN defined: when queue empty and accepted entry is drainable this cycle (REQ-021/022 with fe_btb_rd=0), it writes same cycle without enqueuing (0-cycle latency).
REQ-034 BPU_UPD_BYPASS_EN undefined: every entry is enqueued; minimum latency 1 cycle.

Structure
REQ-035 Package bpu_upd_pkg holds typedef bpu_upd_entry_t (all upd_* payload fields) and state enum {IDLE, WAIT, FORCE}.
REQ-036 Storage is sub-module bpu_upd_fifo (DEPTH x bpu_upd_entry_t, push/pop/full/empty/count); scheduler FSM stays in bpu_update_sched.

Verification
REQ-037 BHT-only update index 5, inc=1, fe_btb_rd=1 -> bht_we=1 index 5 one cycle later; fe_stall=0.
REQ-038 BTB update index 0x1A, fe_btb_rd held 1 -> WAIT for 7 cycles, FORCE, btb_we=1 index 0x1A with fe_stall=1 on cycle 8 (STARVE_LIMIT=8).
REQ-039 Push 4 entries with fe_btb_rd=1, BTB writes -> upd_ready=0, q_count=4; release fe_btb_rd -> 4 writes in order on 4 consecutive cycles.
REQ-040 upd_valid with bht_we=btb_we=0 -> not enqueued, q_count stays 0.
REQ-041 Assert reset_n=0 with 3 entries queued -> q_count=0, no btb_we after release.
REQ-042 With BPU_UPD_BYPASS_EN, empty queue, fe_btb_rd=0, BTB update -> btb_we=1 same cycle; without it -> next cycle.
